// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the picoRISC control unit: holds uPC, resolves branches,
// opcode/mode mapper dispatch and a small micro-subroutine return stack.
module micro_sequencer #(
    parameter int              AW           = 8,
    parameter logic [AW-1:0]   FETCH_ADDR   = 8'd0,
    parameter logic [AW-1:0]   ILLEGAL_ADDR = 8'hF0,
    parameter int              NCOND        = 16,
    parameter int              DEPTH        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic [AW-1:0]     br_target,
    input  logic [NCOND-1:0]  cond_flags,
    input  logic [AW-1:0]     kmop_addr,
    input  logic [AW-1:0]     kmadr_addr,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              start,
    output logic [AW-1:0]     upc,
    output logic              halted,
    output logic              illegal,
    output logic              stack_err
);
    // state | meaning
    // RUN   | sequencing; stall holds everything for the cycle
    // HALT  | upc frozen until start restarts at FETCH_ADDR

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     upc_nxt, upc_inc;
    logic [AW-1:0]     stack_mem [DEPTH];
    logic [CW-1:0]     count, count_m1;
    logic [IW-1:0]     top_idx;
    logic              push, pop, clear;
    logic              cond_hit;
    logic              illegal_nxt, stack_err_nxt;

    assign halted   = (state == S_HALT);
    assign count_m1 = count - CW'(1);
    assign top_idx  = count_m1[IW-1:0];

    always_comb begin
        state_nxt     = state;
        upc_nxt       = upc;
        upc_inc       = upc + AW'(1);
        push          = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        illegal_nxt   = 1'b0;
        stack_err_nxt = 1'b0;
        // Indices beyond the condition vector read as false.
        cond_hit      = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (int'(br_cond) == i) cond_hit = cond_flags[i];
        end

        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else begin
                        case (br_type)
                            3'd0: upc_nxt = upc_inc;
                            3'd1: upc_nxt = br_target;
                            3'd2: upc_nxt = cond_hit ? br_target : upc_inc;
                            3'd3: upc_nxt = !cond_hit ? br_target : upc_inc;
                            3'd4: begin
                                if (kmop_addr == '0) begin
                                    upc_nxt     = ILLEGAL_ADDR;
                                    illegal_nxt = 1'b1;
                                end else begin
                                    upc_nxt = kmop_addr;
                                end
                            end
                            3'd5: begin
                                if (kmadr_addr == '0) begin
                                    upc_nxt     = ILLEGAL_ADDR;
                                    illegal_nxt = 1'b1;
                                end else begin
                                    upc_nxt = kmadr_addr;
                                end
                            end
                            3'd6: begin
                                if (count == CW'(DEPTH)) begin
                                    upc_nxt       = ILLEGAL_ADDR;
                                    illegal_nxt   = 1'b1;
                                    stack_err_nxt = 1'b1;
                                end else begin
                                    push    = 1'b1;
                                    upc_nxt = br_target;
                                end
                            end
                            default: begin
                                if (count == '0) begin
                                    upc_nxt       = FETCH_ADDR;
                                    stack_err_nxt = 1'b1;
                                end else begin
                                    pop     = 1'b1;
                                    upc_nxt = stack_mem[top_idx];
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                    upc_nxt   = FETCH_ADDR;
                    clear     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_RUN;
            upc       <= FETCH_ADDR;
            count     <= '0;
            illegal   <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            upc       <= upc_nxt;
            illegal   <= illegal_nxt;
            stack_err <= stack_err_nxt;
            if (clear)     count <= '0;
            else if (push) count <= count + CW'(1);
            else if (pop)  count <= count_m1;
        end
    end

    // Stack storage needs no reset: the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) stack_mem[count[IW-1:0]] <= upc_inc;
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scenario bench for micro_sequencer: each step drives inputs and queues the
// expected upc/illegal/stack_err/halted seen one clock later.
module tb_micro_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  br_type;
    logic [3:0]  br_cond;
    logic [7:0]  br_target;
    logic [15:0] cond_flags;
    logic [7:0]  kmop_addr;
    logic [7:0]  kmadr_addr;
    logic        stall;
    logic        halt_req;
    logic        start;
    logic [7:0]  upc;
    logic        halted;
    logic        illegal;
    logic        stack_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] upc;
        logic       ill;
        logic       serr;
        logic       hlt;
    } exp_t;

    typedef struct packed {
        logic        rst_n;
        logic [2:0]  bt;
        logic [3:0]  bc;
        logic [7:0]  tgt;
        logic [15:0] flags;
        logic [7:0]  kop;
        logic [7:0]  kadr;
        logic        stall;
        logic        hreq;
        logic        start;
        exp_t        e;
    } step_t;

    exp_t exp_q[$];

    micro_sequencer dut (
        .clk(clk), .rst_n(rst_n), .br_type(br_type), .br_cond(br_cond),
        .br_target(br_target), .cond_flags(cond_flags), .kmop_addr(kmop_addr),
        .kmadr_addr(kmadr_addr), .stall(stall), .halt_req(halt_req), .start(start),
        .upc(upc), .halted(halted), .illegal(illegal), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Plain run step: no stall/halt/start, mapper inputs nonzero.
    function automatic step_t run(input logic [2:0] bt, input logic [3:0] bc,
                                  input logic [7:0] tgt, input logic [15:0] flags,
                                  input logic [7:0] eupc, input logic eill, input logic eserr);
        step_t s;
        s = '{rst_n: 1'b1, bt: bt, bc: bc, tgt: tgt, flags: flags, kop: 8'h01, kadr: 8'h01,
              stall: 1'b0, hreq: 1'b0, start: 1'b0,
              e: '{upc: eupc, ill: eill, serr: eserr, hlt: 1'b0}};
        return s;
    endfunction

    task automatic drive_step(input step_t s);
        rst_n      = s.rst_n;
        br_type    = s.bt;
        br_cond    = s.bc;
        br_target  = s.tgt;
        cond_flags = s.flags;
        kmop_addr  = s.kop;
        kmadr_addr = s.kadr;
        stall      = s.stall;
        halt_req   = s.hreq;
        start      = s.start;
        exp_q.push_back(s.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0));
        s[0].rst_n = 1'b0;
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h01, 1'b0, 1'b0));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h02, 1'b0, 1'b0));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h03, 1'b0, 1'b0));
        s.push_back(run(3'd1, 4'd0, 8'hFF, 16'h0, 8'hFF, 1'b0, 1'b0));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h01, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL reset_next[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    task automatic test_mapper();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd5, 4'd0, 8'h00, 16'h0, 8'd19, 1'b0, 1'b0));
        s[$].kadr = 8'd19;
        s.push_back(run(3'd5, 4'd0, 8'h00, 16'h0, 8'hF0, 1'b1, 1'b0));
        s[$].kadr = 8'h00;
        s.push_back(run(3'd4, 4'd0, 8'h00, 16'h0, 8'h20, 1'b0, 1'b0));
        s[$].kop = 8'h20;
        s.push_back(run(3'd4, 4'd0, 8'h00, 16'h0, 8'hF0, 1'b1, 1'b0));
        s[$].kop = 8'h00;
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'hF1, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL mapper[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    task automatic test_cond();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd1, 4'd0, 8'h20, 16'h0000, 8'h20, 1'b0, 1'b0));
        s.push_back(run(3'd2, 4'd3, 8'h40, 16'h0008, 8'h40, 1'b0, 1'b0));
        s.push_back(run(3'd2, 4'd3, 8'h60, 16'h0000, 8'h41, 1'b0, 1'b0));
        s.push_back(run(3'd3, 4'd3, 8'h40, 16'h0000, 8'h40, 1'b0, 1'b0));
        s.push_back(run(3'd3, 4'd3, 8'h60, 16'h0008, 8'h41, 1'b0, 1'b0));
        s.push_back(run(3'd2, 4'd15, 8'h80, 16'h8000, 8'h80, 1'b0, 1'b0));
        s.push_back(run(3'd2, 4'd3, 8'h40, 16'hFFF7, 8'h81, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL cond[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    task automatic test_stack();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd1, 4'd0, 8'h10, 16'h0, 8'h10, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h20, 16'h0, 8'h20, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h30, 16'h0, 8'h30, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h40, 16'h0, 8'h40, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h50, 16'h0, 8'h50, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h60, 16'h0, 8'hF0, 1'b1, 1'b1));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h41, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h31, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h21, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h11, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b1));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h01, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL stack[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd1, 4'd0, 8'h30, 16'h0, 8'h30, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(run(3'd6, 4'd0, 8'h70, 16'h0, 8'h30, 1'b0, 1'b0));
            s[$].stall = 1'b1;
            s[$].hreq  = (k == 1);
        end
        s.push_back(run(3'd6, 4'd0, 8'h70, 16'h0, 8'h70, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h31, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b1));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    task automatic test_halt();
        step_t s[$];
        exp_t  e, got;
        s.push_back(run(3'd1, 4'd0, 8'h05, 16'h0, 8'h05, 1'b0, 1'b0));
        s.push_back(run(3'd6, 4'd0, 8'h07, 16'h0, 8'h07, 1'b0, 1'b0));
        s.push_back(run(3'd1, 4'd0, 8'h99, 16'h0, 8'h07, 1'b0, 1'b0));
        s[$].hreq = 1'b1;
        s[$].e.hlt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s.push_back(run(3'd1, 4'd0, 8'h55, 16'h0, 8'h07, 1'b0, 1'b0));
            s[$].e.hlt = 1'b1;
        end
        s.push_back(run(3'd1, 4'd0, 8'h55, 16'h0, 8'h00, 1'b0, 1'b0));
        s[$].start = 1'b1;
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b1));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0));
        s[$].hreq = 1'b1;
        s[$].e.hlt = 1'b1;
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0));
        s[$].rst_n = 1'b0;
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h01, 1'b0, 1'b0));
        s.push_back(run(3'd0, 4'd0, 8'h00, 16'h0, 8'h02, 1'b0, 1'b0));
        s[$].start = 1'b1;
        s.push_back(run(3'd6, 4'd0, 8'h33, 16'h0, 8'h33, 1'b0, 1'b0));
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0));
        s[$].rst_n = 1'b0;
        s.push_back(run(3'd7, 4'd0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b1));
        foreach (s[i]) begin
            drive_step(s[i]);
            got = '{upc: upc, ill: illegal, serr: stack_err, hlt: halted};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL halt[%0d]: got upc=%h ill=%b serr=%b hlt=%b, want upc=%h ill=%b serr=%b hlt=%b",
                         i, got.upc, got.ill, got.serr, got.hlt, e.upc, e.ill, e.serr, e.hlt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; br_type = '0; br_cond = '0; br_target = '0; cond_flags = '0;
        kmop_addr = 8'h01; kmadr_addr = 8'h01; stall = 1'b0; halt_req = 1'b0; start = 1'b0;
        test_reset();
        test_mapper();
        test_cond();
        test_stack();
        test_stall();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
